ram_banked: RTL and testbench

- Parametrised successor to the team's 16-bit dual-bank byte RAM.
- Data width is generalised to NUM_LANES byte banks, with arbitrary byte-aligned (unaligned) access, per-byte write strobes and configurable wait states.
- Adds an explicit request FSM, an out-of-range error response and address wrap-around.
- Sits on the core's valid/ready memory bus as instruction/data RAM.

---
 rtl/ram_banked_pkg.sv | 50 +++++
 rtl/ram_bank.sv | 33 +++
 rtl/ram_banked.sv | 129 ++++++++++++
 tb/tb_ram_banked.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_banked_pkg.sv
// rtl/ram_banked_pkg.sv - shared types and lane/bank mapping helpers for ram_banked
package ram_banked_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] bank;
        logic [31:0] row;
    } bank_loc_t;

    // Byte k of data moves to byte position (k + shift) mod lanes.
    function automatic logic [63:0] rotl_bytes(input logic [63:0] data, input int shift, input int lanes);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < lanes) begin
                r[8*j +: 8] = data[8*((j - shift + lanes) % lanes) +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl_bits(input logic [7:0] data, input int shift, input int lanes);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < lanes) begin
                r[j] = data[(j - shift + lanes) % lanes];
            end
        end
        return r;
    endfunction

    // Byte lane of a transfer starting at addr lands here; wraps at the top of memory.
    function automatic bank_loc_t bank_map(input logic [31:0] addr, input int lane, input int lanes,
                                           input int mem_size);
        bank_loc_t   loc;
        logic [31:0] b;
        b = (addr + 32'(lane)) % 32'(mem_size);
        loc.bank = b % 32'(lanes);
        loc.row = b / 32'(lanes);
        return loc;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - one byte-wide synchronous RAM bank, read-first, registered output
module ram_bank #(
    parameter int    ROWS      = 4096,
    parameter int    ROW_W     = 12,
    parameter int    BANK_IDX  = 0,
    parameter string INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             we,
    input  logic [ROW_W-1:0] row,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[row] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[row];
        end
    end

endmodule

// File: rtl/ram_banked.sv
// rtl/ram_banked.sv - multi-bank byte RAM with unaligned access, strobes, wait states and range error
module ram_banked
    import ram_banked_pkg::*;
#(
    parameter int    DATA_WIDTH  = 16,
    parameter int    MEM_SIZE    = 16'h8000,
    parameter int    ADDR_WIDTH  = 16,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    ready,
    output logic                    err
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int LANE_W    = $clog2(NUM_LANES);
    localparam int ROWS      = MEM_SIZE / NUM_LANES;
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              wait_cnt;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [NUM_LANES-1:0]    wstrb_r;
    logic                    err_r;
    logic [LANE_W-1:0]       rot_r;

    logic                    accept;
    logic                    access_en;
    logic                    out_of_range;
    logic [LANE_W-1:0]       lane_off;
    logic [DATA_WIDTH-1:0]   bank_wdata;
    logic [NUM_LANES-1:0]    bank_strb;
    logic [DATA_WIDTH-1:0]   bank_q;
    logic [NUM_LANES-1:0][ROW_W-1:0] bank_row_sel;
    bank_loc_t               loc;

    assign accept       = (state == IDLE) && valid;
    assign access_en    = (state == ACCESS);
    assign out_of_range = 32'(addr_r) >= 32'(MEM_SIZE);
    assign lane_off     = addr_r[LANE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid) state_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (wait_cnt == 4'd0) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= '0;
            wdata_r <= '0;
            wstrb_r <= '0;
            err_r   <= 1'b0;
            rot_r   <= '0;
        end else if (accept) begin
            addr_r  <= addr;
            wdata_r <= wdata;
            wstrb_r <= wstrb;
        end else if (access_en) begin
            err_r <= out_of_range;
            rot_r <= lane_off;
        end
    end

    assign bank_wdata = DATA_WIDTH'(rotl_bytes(64'(wdata_r), int'(lane_off), NUM_LANES));
    assign bank_strb  = NUM_LANES'(rotl_bits(8'(wstrb_r), int'(lane_off), NUM_LANES));

    // Route each transfer lane's row to whichever bank that lane lands in.
    always_comb begin
        bank_row_sel = '0;
        loc          = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            loc = bank_map(32'(addr_r), k, NUM_LANES, MEM_SIZE);
            bank_row_sel[LANE_W'(loc.bank)] = ROW_W'(loc.row);
        end
    end

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_bank
        ram_bank #(
            .ROWS      (ROWS),
            .ROW_W     (ROW_W),
            .BANK_IDX  (j),
            .INIT_FILE (INIT_FILE)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (access_en),
            .we    (bank_strb[j] && !out_of_range),
            .row   (bank_row_sel[j]),
            .wdata (bank_wdata[8*j +: 8]),
            .rdata (bank_q[8*j +: 8])
        );
    end

    assign rdata = err_r ? '0
                 : DATA_WIDTH'(rotl_bytes(64'(bank_q), (NUM_LANES - int'(rot_r)) % NUM_LANES, NUM_LANES));
    assign ready = (state == RESP);
    assign err   = err_r;

endmodule

// File: tb/tb_ram_banked.sv
// tb/tb_ram_banked.sv - randomized scoreboard bench for ram_banked (WAIT_STATES 0 and 3)
module tb_ram_banked;

    localparam int DW = 32;
    localparam int NL = 4;
    localparam int AW = 16;
    localparam int MS = 32'h8000;

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        logic          e;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]             rst_n;
    logic [1:0]             valid;
    logic [1:0][AW-1:0]     addr;
    logic [1:0][DW-1:0]     wdata;
    logic [1:0][NL-1:0]     wstrb;
    wire  [1:0][DW-1:0]     rdata;
    wire  [1:0]             ready;
    wire  [1:0]             err;

    int total = 0;
    int bad = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] mem_m   [2][MS];
    bit         known_m [2][MS];

    logic [DW-1:0] last_rdata;
    logic          last_err;

    ram_banked #(.DATA_WIDTH(DW), .MEM_SIZE(MS), .ADDR_WIDTH(AW), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .valid(valid[0]), .addr(addr[0]), .wdata(wdata[0]),
        .wstrb(wstrb[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0]));

    ram_banked #(.DATA_WIDTH(DW), .MEM_SIZE(MS), .ADDR_WIDTH(AW), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
        .clk(clk), .rst_n(rst_n[1]), .valid(valid[1]), .addr(addr[1]), .wdata(wdata[1]),
        .wstrb(wstrb[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: byte-addressed memory, wrap modulo MS, read returns old bytes.
    task automatic model(input int d, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [NL-1:0] ws, output exp_t e);
        int b;
        e.data = '0;
        e.mask = '0;
        e.e    = (int'(a) >= MS);
        if (e.e) begin
            e.mask = '1;
            return;
        end
        for (int k = 0; k < NL; k++) begin
            b = (int'(a) + k) % MS;
            e.data[8*k +: 8] = mem_m[d][b];
            if (known_m[d][b]) e.mask[8*k +: 8] = 8'hFF;
            if (ws[k]) begin
                mem_m[d][b]   = wd[8*k +: 8];
                known_m[d][b] = 1'b1;
            end
        end
    endtask

    task automatic check_resp(input int d);
        exp_t e;
        total++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_ready dut%0d: got ready=1 expected no response", d);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (((rdata[d] & e.mask) !== (e.data & e.mask)) || (err[d] !== e.e)) begin
            bad++;
            $display("FAIL resp dut%0d: got rdata=%h err=%b expected rdata=%h (mask %h) err=%b",
                     d, rdata[d], err[d], e.data, e.mask, e.e);
        end
    endtask

    always @(negedge clk) if (ready[0] === 1'b1) check_resp(0);
    always @(negedge clk) if (ready[1] === 1'b1) check_resp(1);

    task automatic req(input int d, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [NL-1:0] ws, input bit b2b);
        exp_t e;
        int   cyc;
        int   lat;
        model(d, a, wd, ws, e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        lat = ((d == 0) ? 0 : 3) + (b2b ? 3 : 2);
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        addr[d]  = a;
        wdata[d] = wd;
        wstrb[d] = ws;
        valid[d] = 1'b1;
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (ready[d] === 1'b1) break;
            if (cyc > 40) begin
                total++;
                bad++;
                $display("FAIL timeout dut%0d addr=%h: got no ready expected ready within 40 cycles", d, a);
                if (d == 0) void'(q0.pop_back());
                else        void'(q1.pop_back());
                valid[d] = 1'b0;
                return;
            end
        end
        chk($sformatf("latency dut%0d", d), 64'(cyc), 64'(lat));
        last_rdata = rdata[d];
        last_err   = err[d];
        valid[d]   = 1'b0;
    endtask

    task automatic random_run(input int d, input int n);
        logic [AW-1:0] a;
        logic [NL-1:0] ws;
        bit            b2b;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = AW'($urandom_range(0, 63));
                2:       a = AW'(MS - 8 + int'($urandom_range(0, 7)));
                default: a = ($urandom_range(0, 1) == 1) ? 16'hFFFF : AW'(MS + int'($urandom_range(0, 3)));
            endcase
            ws  = ($urandom_range(0, 2) == 0) ? '0 : NL'($urandom());
            b2b = (i > 0) && ($urandom_range(0, 1) == 1);
            req(d, a, DW'($urandom()), ws, b2b);
        end
    endtask

    initial begin
        rst_n = 2'b00;
        valid = 2'b00;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset ready dut%0d", d), 64'(ready[d]), 64'd0);
            chk($sformatf("reset err dut%0d", d), 64'(err[d]), 64'd0);
            chk($sformatf("reset rdata dut%0d", d), 64'(rdata[d]), 64'd0);
        end
        rst_n = 2'b11;

        for (int d = 0; d < 2; d++) begin
            req(d, 16'h0010, 32'hDEADBEEF, 4'hF, 0);
            req(d, 16'h0010, 32'h0, 4'h0, 0);
            chk($sformatf("aligned read dut%0d", d), 64'(last_rdata), 64'hDEADBEEF);
            chk($sformatf("aligned err dut%0d", d), 64'(last_err), 64'd0);

            req(d, 16'h0013, 32'h44332211, 4'hF, 0);
            req(d, 16'h0010, 32'h0, 4'h0, 0);
            chk($sformatf("unaligned lo dut%0d", d), 64'(last_rdata[31:24]), 64'h11);
            req(d, 16'h0014, 32'h0, 4'h0, 1);
            chk($sformatf("unaligned hi dut%0d", d), 64'(last_rdata[23:0]), 64'h443322);
            req(d, 16'h0013, 32'h0, 4'h0, 1);
            chk($sformatf("unaligned full dut%0d", d), 64'(last_rdata), 64'h44332211);

            req(d, 16'h0020, 32'h0, 4'hF, 0);
            req(d, 16'h0020, 32'hAABBCCDD, 4'b0101, 1);
            req(d, 16'h0020, 32'h0, 4'h0, 1);
            chk($sformatf("partial dut%0d", d), 64'(last_rdata), 64'h00BB00DD);

            req(d, AW'(MS), 32'h0, 4'h0, 0);
            chk($sformatf("oor read err dut%0d", d), 64'(last_err), 64'd1);
            chk($sformatf("oor read rdata dut%0d", d), 64'(last_rdata), 64'd0);
            req(d, AW'(MS), 32'h12345678, 4'hF, 1);
            chk($sformatf("oor write err dut%0d", d), 64'(last_err), 64'd1);

            req(d, AW'(MS - 2), 32'h55667788, 4'hF, 0);
            chk($sformatf("wrap write err dut%0d", d), 64'(last_err), 64'd0);
            req(d, 16'h0000, 32'h0, 4'h0, 1);
            chk($sformatf("wrap low bytes dut%0d", d), 64'(last_rdata[15:0]), 64'h5566);

            random_run(d, 120);
        end

        req(1, 16'h0040, 32'h0A0B0C0D, 4'hF, 0);
        @(posedge clk);
        #1;
        addr[1]  = 16'h0040;
        wdata[1] = 32'hFFFFFFFF;
        wstrb[1] = 4'hF;
        valid[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n[1] = 1'b0;
        valid[1] = 1'b0;
        #1;
        chk("midreset ready", 64'(ready[1]), 64'd0);
        chk("midreset err", 64'(err[1]), 64'd0);
        chk("midreset rdata", 64'(rdata[1]), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("midreset hold ready", 64'(ready[1]), 64'd0);
        end
        rst_n[1] = 1'b1;
        repeat (6) @(negedge clk);
        req(1, 16'h0040, 32'h0, 4'h0, 0);
        chk("midreset dropped write", 64'(last_rdata), 64'h0A0B0C0D);

        repeat (4) @(negedge clk);
        chk("scoreboard drained dut0", 64'(q0.size()), 64'd0);
        chk("scoreboard drained dut3", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
